// File: rtl/crop_word_packer.sv
// Packs a crop's normalised pixel stream into wide words.
// The last word of each crop carries tlast; completed crops are counted.
module crop_word_packer #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int OUT_ROWS        = 20,
    parameter int OUT_COLS        = 20,
    parameter int PIXELS_PER_WORD = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       flush,
    input  logic                                       s_axis_tvalid,
    output logic                                       s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]                 s_axis_tdata,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic [PIXELS_PER_WORD*PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
    output logic                                       m_axis_tlast,
    output logic                                       frame_done,
    output logic [15:0]                                frame_cnt
);

    localparam int WORD_W = PIXELS_PER_WORD * PIXEL_BIT_WIDTH;
    localparam int N_PIX  = OUT_ROWS * OUT_COLS;
    localparam int LANE_W = $clog2(PIXELS_PER_WORD);
    localparam int PIX_W  = (N_PIX > 1) ? $clog2(N_PIX) : 1;

    logic [LANE_W-1:0] lane_q;
    logic [PIX_W-1:0]  pix_q;
    logic [WORD_W-1:0] pack_q;
    logic [WORD_W-1:0] word_d;
    logic              last_pix;
    logic              closing;
    logic              accept;
    logic              m_hs;

    assign last_pix = (pix_q == PIX_W'(N_PIX - 1));
    assign closing  = (lane_q == LANE_W'(PIXELS_PER_WORD - 1)) || last_pix;
    // A closing pixel is only taken when its word can enter the output register.
    assign s_axis_tready = reset && !flush &&
                           (!closing || !m_axis_tvalid || m_axis_tready);
    assign accept = s_axis_tvalid && s_axis_tready;
    assign m_hs   = m_axis_tvalid && m_axis_tready;

    // Merge the incoming pixel into its lane of the partially built word.
    always_comb begin
        word_d = pack_q;
        for (int k = 0; k < PIXELS_PER_WORD; k++) begin
            if (lane_q == LANE_W'(k)) begin
                word_d[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = s_axis_tdata;
            end
        end
    end

    // Lane / pixel counters and pack register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= '0;
            pix_q  <= '0;
            pack_q <= '0;
        end else if (flush) begin
            lane_q <= '0;
            pix_q  <= '0;
            pack_q <= '0;
        end else if (accept) begin
            if (closing) begin
                lane_q <= '0;
                pack_q <= '0;
            end else begin
                lane_q <= lane_q + 1'b1;
                pack_q <= word_d;
            end
            pix_q <= last_pix ? '0 : pix_q + 1'b1;
        end
    end

    // Output register: load on a closing pixel, drop on drain or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (flush) begin
            m_axis_tvalid <= 1'b0;
        end else if (accept && closing) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= word_d;
            m_axis_tlast  <= last_pix;
        end else if (m_hs) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Completed-crop pulse and counter, one cycle after the tlast handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= m_hs && m_axis_tlast;
            if (m_hs && m_axis_tlast) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_crop_word_packer.sv
// Directed bench for crop_word_packer with a 5x5 crop and 4 pixels/word.
// Words are captured on handshake and compared with an expected word list.
module tb_crop_word_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        s_tvalid;
    logic        s_tready;
    logic [9:0]  s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [39:0] m_tdata;
    logic        m_tlast;
    logic        frame_done;
    logic [15:0] frame_cnt;

    crop_word_packer #(
        .PIXEL_BIT_WIDTH(10),
        .OUT_ROWS(5),
        .OUT_COLS(5),
        .PIXELS_PER_WORD(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    base;
        int    npix;
        int    pct;
        int    nwords;
        int    frames;
    } vec_t;

    int nvec = 0;
    int miss = 0;

    logic [39:0] got_d[$];
    logic        got_l[$];
    logic [39:0] exp_d[$];
    logic        exp_l[$];

    int          cyc = 0;
    int          fd_cnt;
    int          sready_low;
    int          sready_bad;
    int          stall_bad;
    int          first_v;
    int          p4_cyc;
    logic        acc;
    logic        prev_stall = 1'b0;
    logic [39:0] prev_d;
    logic        prev_l;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic clear_obs();
        got_d.delete();
        got_l.delete();
        exp_d.delete();
        exp_l.delete();
        fd_cnt     = 0;
        sready_low = 0;
        sready_bad = 0;
        stall_bad  = 0;
        first_v    = -1;
        p4_cyc     = -1;
        prev_stall = 1'b0;
    endtask

    // One clock: observe at the falling edge, return 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            if (m_tvalid && m_tready) begin
                got_d.push_back(m_tdata);
                got_l.push_back(m_tlast);
            end
            if (prev_stall && (m_tdata !== prev_d || m_tlast !== prev_l))
                stall_bad++;
            if (!s_tready) sready_low++;
            if (!s_tready && !flush && !(m_tvalid && !m_tready))
                sready_bad++;
            if (frame_done) fd_cnt++;
            if (m_tvalid && first_v < 0) first_v = cyc;
            prev_stall = m_tvalid && !m_tready && !flush;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
            acc        = s_tvalid && s_tready;
        end else begin
            acc        = 1'b0;
            prev_stall = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        flush    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Expected words for n consecutive pixel values starting at a crop start.
    task automatic build_exp(input int base, input int n);
        logic [39:0] w;
        int          lane;
        int          idx;
        w    = '0;
        lane = 0;
        idx  = 0;
        for (int i = 0; i < n; i++) begin
            w[lane*10 +: 10] = 10'(base + i);
            if (lane == 3 || idx == 24) begin
                exp_d.push_back(w);
                exp_l.push_back(idx == 24);
                w    = '0;
                lane = 0;
            end else begin
                lane++;
            end
            idx = (idx == 24) ? 0 : idx + 1;
        end
    endtask

    task automatic stream(input int base, input int n, input int pct);
        int guard;
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 10'(base + i);
            guard    = 0;
            do begin
                m_tready = ($urandom_range(99) < pct);
                tick();
                guard++;
            end while (!acc && guard < 200);
            if (!acc) begin
                chk("pixel_accept_timeout", 0, 1);
                break;
            end
            if (i == 3) p4_cyc = cyc - 1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (5) tick();
    endtask

    task automatic cmp_words(input string nm);
        int n;
        chk({nm, "_word_count"}, got_d.size(), exp_d.size());
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_w%0d_data", nm, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_w%0d_last", nm, i), got_l[i], exp_l[i]);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_s_tready"}, s_tready, 0);
        chk({nm, "_m_tvalid"}, m_tvalid, 0);
        chk({nm, "_m_tdata"}, m_tdata, 0);
        chk({nm, "_m_tlast"}, m_tlast, 0);
        chk({nm, "_frame_done"}, frame_done, 0);
        chk({nm, "_frame_cnt"}, frame_cnt, 0);
    endtask

    vec_t vt[3];

    initial begin
        vt[0] = '{"single",    1,  25, 100,  7, 1};
        vt[1] = '{"rand_rdy",  1,  25,  50,  7, 1};
        vt[2] = '{"b2b",       1,  50, 100, 14, 2};

        reset    = 1'b0;
        flush    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;

        // Reset held with random inputs: every output stays 0.
        repeat (4) begin
            flush    = 1'($urandom);
            s_tvalid = 1'($urandom);
            s_tdata  = 10'($urandom);
            m_tready = 1'($urandom);
            tick();
            chk_all_zero("reset_hold");
        end
        flush    = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        reset    = 1'b1;
        tick();
        chk("post_reset_s_tready", s_tready, 1);
        chk("post_reset_m_tvalid", m_tvalid, 0);

        // Table-driven streaming scenarios.
        for (int v = 0; v < 3; v++) begin
            do_reset();
            clear_obs();
            build_exp(vt[v].base, vt[v].npix);
            stream(vt[v].base, vt[v].npix, vt[v].pct);
            drain();
            cmp_words(vt[v].name);
            chk({vt[v].name, "_nwords"}, got_d.size(), vt[v].nwords);
            chk({vt[v].name, "_frame_done"}, fd_cnt, vt[v].frames);
            chk({vt[v].name, "_frame_cnt"}, frame_cnt, vt[v].frames);
            chk({vt[v].name, "_latency"}, first_v - p4_cyc, 1);
            chk({vt[v].name, "_stall_stable"}, stall_bad, 0);
            chk({vt[v].name, "_sready_cause"}, sready_bad, 0);
            if (vt[v].pct == 100)
                chk({vt[v].name, "_sready_low"}, sready_low, 0);
            if (v == 2 && got_d.size() >= 14) begin
                chk("b2b_w7_lane0", got_d[7][9:0], 26);
                chk("b2b_w7_lane3", got_d[7][39:30], 29);
                chk("b2b_w13_lane0", got_d[13][9:0], 50);
            end
        end

        // Flush after 10 pixels, then a fresh crop of 100..124.
        do_reset();
        clear_obs();
        stream(1, 10, 100);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        flush    = 1'b1;
        #1;
        chk("flush_s_tready", s_tready, 0);
        tick();
        flush = 1'b0;
        chk("flush_m_tvalid", m_tvalid, 0);
        chk("flush_frame_cnt", frame_cnt, 0);
        stream(100, 25, 100);
        drain();
        build_exp(1, 8);
        build_exp(100, 25);
        cmp_words("flush");
        if (got_d.size() == 9) begin
            chk("flush_first_word", got_d[2],
                {10'd103, 10'd102, 10'd101, 10'd100});
            chk("flush_last_word", got_d[8], {30'd0, 10'd124});
            chk("flush_last_tlast", got_l[8], 1);
        end
        chk("flush_frame_cnt_end", frame_cnt, 1);
        chk("flush_frame_done", fd_cnt, 1);

        // Async reset mid-word with a stalled output word.
        do_reset();
        clear_obs();
        stream(1, 6, 0);
        m_tready = 1'b0;
        chk("midrst_pre_stalled", m_tvalid, 1);
        reset = 1'b0;
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_m_tdata", m_tdata, 0);
        chk("midrst_m_tlast", m_tlast, 0);
        chk("midrst_s_tready", s_tready, 0);
        tick();
        reset = 1'b1;
        tick();
        clear_obs();
        build_exp(1, 25);
        stream(1, 25, 100);
        drain();
        cmp_words("midrst");
        if (got_d.size() == 7) begin
            chk("midrst_w0", got_d[0], {10'd4, 10'd3, 10'd2, 10'd1});
            chk("midrst_w6", got_d[6], {30'd0, 10'd25});
            chk("midrst_w6_last", got_l[6], 1);
        end
        chk("midrst_frame_cnt", frame_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
        $finish;
    end

endmodule
